// File: rtl/cim_host_sequencer.sv
// Host-side initiator for the 8-bit compute-in-SRAM macro: turns NOP/WRITE/READ/COMPUTE
// requests into the macro pin protocol and returns sampled results on a response channel.
module cim_host_sequencer #(
    parameter int RESP_LAT   = 2,
    parameter int RST_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [3:0] req_addr,
    input  logic [1:0] req_func,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [1:0] rsp_op,
    output logic [7:0] rsp_data,
    output logic [7:0] pin_ui,
    output logic [7:0] pin_uio,
    output logic [7:0] pin_uio_drive,
    input  logic [7:0] pin_uo,
    output logic       pin_rst_n,
    output logic       pin_ena,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_READ    = 2'b10;
    localparam logic [1:0] OP_COMPUTE = 2'b11;

    localparam int              WAIT_W    = $clog2(RESP_LAT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RESP_LAT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [3:0]        INIT_LAST = 4'(RST_CYCLES - 1);

    state_t            state, state_d;
    logic [3:0]        init_cnt, init_cnt_d;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_d;
    logic [1:0]        cur_op, cur_op_d;
    logic              rsp_valid_d;
    logic [1:0]        rsp_op_d;
    logic [7:0]        rsp_data_d;
    logic [7:0]        pin_ui_d, pin_uio_d, pin_uio_drive_d;
    logic              pin_rst_n_d, pin_ena_d, busy_d;

    assign req_ready = (state == S_IDLE);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can leave
        // one unassigned and infer a latch.
        state_d         = state;
        init_cnt_d      = init_cnt;
        wait_cnt_d      = wait_cnt;
        cur_op_d        = cur_op;
        rsp_valid_d     = rsp_valid;
        rsp_op_d        = rsp_op;
        rsp_data_d      = rsp_data;
        pin_ui_d        = 8'h00;
        pin_uio_d       = 8'h00;
        pin_uio_drive_d = 8'h00;
        pin_rst_n_d     = pin_rst_n;
        pin_ena_d       = pin_ena;

        unique case (state)
            S_INIT: begin
                // Release the macro first, then give it one quiet cycle before IDLE.
                if (!pin_rst_n) begin
                    if (init_cnt == INIT_LAST) begin
                        pin_rst_n_d = 1'b1;
                        pin_ena_d   = 1'b1;
                    end else begin
                        init_cnt_d = init_cnt + 4'd1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                if (req_valid) begin
                    state_d  = S_ISSUE;
                    cur_op_d = req_op;
                    pin_ui_d = {req_op, req_addr, req_func};
                    unique case (req_op)
                        OP_WRITE: begin
                            pin_uio_d       = req_data;
                            pin_uio_drive_d = 8'hFF;
                        end
                        OP_COMPUTE: begin
                            pin_uio_d       = {4'h0, req_data[3:0]};
                            pin_uio_drive_d = 8'hFF;
                        end
                        default: begin
                            pin_uio_d       = 8'h00;
                            pin_uio_drive_d = 8'h00;
                        end
                    endcase
                end
            end

            S_ISSUE: begin
                if (cur_op == OP_NOP || cur_op == OP_WRITE) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_op_d    = cur_op;
                    rsp_data_d  = 8'h00;
                end else begin
                    state_d    = S_WAIT;
                    wait_cnt_d = WAIT_LOAD;
                end
            end

            S_WAIT: begin
                if (wait_cnt == WAIT_ONE) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_op_d    = cur_op;
                    rsp_data_d  = pin_uo;
                end else begin
                    wait_cnt_d = wait_cnt - WAIT_ONE;
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end

            default: state_d = S_INIT;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state         <= S_INIT;
            init_cnt      <= 4'd0;
            wait_cnt      <= '0;
            cur_op        <= OP_NOP;
            rsp_valid     <= 1'b0;
            rsp_op        <= 2'b00;
            rsp_data      <= 8'h00;
            pin_ui        <= 8'h00;
            pin_uio       <= 8'h00;
            pin_uio_drive <= 8'h00;
            pin_rst_n     <= 1'b0;
            pin_ena       <= 1'b0;
            busy          <= 1'b1;
        end else begin
            state         <= state_d;
            init_cnt      <= init_cnt_d;
            wait_cnt      <= wait_cnt_d;
            cur_op        <= cur_op_d;
            rsp_valid     <= rsp_valid_d;
            rsp_op        <= rsp_op_d;
            rsp_data      <= rsp_data_d;
            pin_ui        <= pin_ui_d;
            pin_uio       <= pin_uio_d;
            pin_uio_drive <= pin_uio_drive_d;
            pin_rst_n     <= pin_rst_n_d;
            pin_ena       <= pin_ena_d;
            busy          <= busy_d;
        end
    end

    // Unused op code kept for readability of the encoding table.
    logic unused_read_code;
    assign unused_read_code = ^OP_READ;

endmodule

// File: tb/tb_cim_host_sequencer.sv
// Directed self-checking bench for cim_host_sequencer with hand-computed pin and response values.
module tb_cim_host_sequencer;

    localparam int RESP_LAT   = 2;
    localparam int RST_CYCLES = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [3:0] req_addr = 4'h0;
    logic [1:0] req_func = 2'b00;
    logic [7:0] req_data = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [1:0] rsp_op;
    logic [7:0] rsp_data;
    logic [7:0] pin_ui;
    logic [7:0] pin_uio;
    logic [7:0] pin_uio_drive;
    logic [7:0] pin_uo = 8'h00;
    logic       pin_rst_n;
    logic       pin_ena;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    cim_host_sequencer #(
        .RESP_LAT  (RESP_LAT),
        .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_func     (req_func),
        .req_data     (req_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_op       (rsp_op),
        .rsp_data     (rsp_data),
        .pin_ui       (pin_ui),
        .pin_uio      (pin_uio),
        .pin_uio_drive(pin_uio_drive),
        .pin_uo       (pin_uo),
        .pin_rst_n    (pin_rst_n),
        .pin_ena      (pin_ena),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds rst for n edges and checks the reset values after the first one.
    task automatic apply_reset(input int n);
        rst       = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        tick();
        @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 8'h00);
        check("rst_rsp_op", rsp_op, 2'b00);
        check("rst_pin_ui", pin_ui, 8'h00);
        check("rst_pin_uio", pin_uio, 8'h00);
        check("rst_pin_drive", pin_uio_drive, 8'h00);
        check("rst_pin_rst_n", pin_rst_n, 1'b0);
        check("rst_pin_ena", pin_ena, 1'b0);
        check("rst_busy", busy, 1'b1);
        check("rst_req_ready", req_ready, 1'b0);
        repeat (n - 1) tick();
    endtask

    // Drops rst and measures the macro reset pulse and the IDLE entry.
    task automatic release_reset();
        int low = 0;
        int noisy = 0;
        rst = 1'b0;
        @(negedge clk);
        while (pin_rst_n === 1'b0 && low < 32) begin
            low++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || pin_ena !== 1'b0 || busy !== 1'b1)
                noisy++;
            @(negedge clk);
        end
        check("init_low_cycles", low, RST_CYCLES);
        check("init_quiet", noisy, 0);
        check("init_ena_with_rst_n", pin_ena, 1'b1);
        check("init_ready_not_yet", req_ready, 1'b0);
        @(negedge clk);
        check("init_ready_after", req_ready, 1'b1);
        check("init_busy_low", busy, 1'b0);
        tick();
    endtask

    // One full request: pins in the issue cycle, the wait window, response and handshake.
    task automatic run_req(input string name, input logic [1:0] op, input logic [3:0] addr,
                           input logic [1:0] func, input logic [7:0] data,
                           input logic [7:0] uo_val, input logic [7:0] exp_ui,
                           input logic [7:0] exp_uio, input logic [7:0] exp_drv,
                           input logic [7:0] exp_rsp, input int hold);
        int waited = 0;
        while (req_ready !== 1'b1 && waited < 32) begin
            tick();
            waited++;
        end
        check({name, "_ready"}, req_ready, 1'b1);
        check({name, "_idle_ui"}, pin_ui, 8'h00);
        check({name, "_idle_drv"}, pin_uio_drive, 8'h00);

        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_func  = func;
        req_data  = data;
        pin_uo    = ~uo_val;
        tick();

        // Fields change and req_valid stays high while busy; both must be ignored.
        req_op   = ~op;
        req_addr = ~addr;
        req_data = ~data;
        @(negedge clk);
        check({name, "_ui"}, pin_ui, exp_ui);
        check({name, "_uio"}, pin_uio, exp_uio);
        check({name, "_drv"}, pin_uio_drive, exp_drv);
        check({name, "_busy"}, busy, 1'b1);
        check({name, "_ready_low"}, req_ready, 1'b0);
        check({name, "_no_early_rsp"}, rsp_valid, 1'b0);
        tick();

        if (op[1]) begin
            for (int k = 2; k <= RESP_LAT + 1; k++) begin
                pin_uo = (k == RESP_LAT + 1) ? uo_val : ~uo_val;
                @(negedge clk);
                check({name, "_wait_rsp"}, rsp_valid, 1'b0);
                check({name, "_wait_ui"}, pin_ui, 8'h00);
                check({name, "_wait_drv"}, pin_uio_drive, 8'h00);
                tick();
            end
        end

        pin_uo    = ~uo_val;
        req_valid = 1'b0;
        @(negedge clk);
        check({name, "_rsp_valid"}, rsp_valid, 1'b1);
        check({name, "_rsp_data"}, rsp_data, exp_rsp);
        check({name, "_rsp_op"}, rsp_op, op);

        for (int h = 0; h < hold; h++) begin
            tick();
            req_valid = ~req_valid;
            pin_uo    = 8'(h * 37 + 1);
            @(negedge clk);
            check({name, "_hold_valid"}, rsp_valid, 1'b1);
            check({name, "_hold_data"}, rsp_data, exp_rsp);
            check({name, "_hold_ready"}, req_ready, 1'b0);
            check({name, "_hold_ui"}, pin_ui, 8'h00);
        end

        tick();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check({name, "_hs_valid"}, rsp_valid, 1'b1);
        tick();
        rsp_ready = 1'b0;
        @(negedge clk);
        check({name, "_done_valid"}, rsp_valid, 1'b0);
        check({name, "_done_ready"}, req_ready, 1'b1);
        check({name, "_done_busy"}, busy, 1'b0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset(3);
        release_reset();

        //       name        op     addr  func   data   uo     ui     uio    drv    rsp    hold
        run_req("write",   2'b01, 4'h5, 2'b00, 8'hA7, 8'h00, 8'h54, 8'hA7, 8'hFF, 8'h00, 0);
        run_req("read",    2'b10, 4'h5, 2'b00, 8'h00, 8'hA7, 8'h94, 8'h00, 8'h00, 8'hA7, 0);
        run_req("compute", 2'b11, 4'h3, 2'b10, 8'h09, 8'h3C, 8'hCE, 8'h09, 8'hFF, 8'h3C, 0);
        run_req("cmp_mask", 2'b11, 4'hA, 2'b01, 8'hF6, 8'h81, 8'hE9, 8'h06, 8'hFF, 8'h81, 0);
        run_req("nop",     2'b00, 4'hF, 2'b01, 8'h55, 8'hFF, 8'h3D, 8'h00, 8'h00, 8'h00, 0);
        run_req("bp_read", 2'b10, 4'h7, 2'b11, 8'h00, 8'hC3, 8'h9F, 8'h00, 8'h00, 8'hC3, 5);

        // Reset while a READ is waiting: the response must be dropped and INIT rerun.
        while (req_ready !== 1'b1) tick();
        req_valid = 1'b1;
        req_op    = 2'b10;
        req_addr  = 4'h5;
        req_func  = 2'b00;
        tick();
        req_valid = 1'b0;
        tick();
        pin_uo = 8'hA7;
        @(negedge clk);
        check("midwait_in_wait", busy, 1'b1);
        tick();
        apply_reset(2);
        pin_uo = 8'h00;
        release_reset();

        run_req("post_rst", 2'b10, 4'hC, 2'b00, 8'h00, 8'h5A, 8'hB0, 8'h00, 8'h00, 8'h5A, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cim_host_sequencer.md
Name: cim_host_sequencer

Overview:
- Host-side initiator for the 8-bit vector compute-in-SRAM macro; drives its dedicated and bidirectional pin bus from the other end of the interface.
- Accepts high-level requests (NOP, WRITE, READ, COMPUTE) on a valid/ready channel and encodes each into the macro's pin protocol.
- For READ and COMPUTE, waits the macro's fixed response latency, samples the result byte and returns it on a valid/ready response channel.
- Used as the bench/FPGA-side driver and as the reusable master for system-level tests.

Parameters:
- RESP_LAT, 2, cycles from command cycle to valid result on pin_uo; legal range 1..15.
- RST_CYCLES, 4, cycles pin_rst_n is held low after rst deasserts; legal range 1..15.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  2  00 NOP, 01 WRITE, 10 READ, 11 COMPUTE.
- req_addr  in  4  SRAM row address (operand A for COMPUTE).
- req_func  in  2  compute function code, passed through unchanged.
- req_data  in  8  write data; for COMPUTE, bits [3:0] are operand-B address.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_op  out  2  op of the completed request.
- rsp_data  out  8  sampled result; 0x00 for NOP and WRITE.
- pin_ui  out  8  macro ui_in: command byte {op[1:0], addr[3:0], func[1:0]}.
- pin_uio  out  8  macro uio_in: data or operand B.
- pin_uio_drive  out  8  1 means the host drives that uio bit.
- pin_uo  in  8  macro uo_out.
- pin_rst_n  out  1  macro reset, active low.
- pin_ena  out  1  macro enable.
- busy  out  1  high in every state except IDLE.

Behaviour:
- State flow: INIT -> IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs are registered except req_ready, which equals (state == IDLE).
- Reset values: state INIT; rsp_valid 0; rsp_data 0x00; rsp_op 00; pin_ui 0x00; pin_uio 0x00; pin_uio_drive 0x00; pin_rst_n 0; pin_ena 0; busy 1.
- INIT: pin_rst_n stays low for RST_CYCLES cycles after the last cycle rst is high, then goes high. pin_ena goes high in the same cycle. The state moves to IDLE one cycle later, so the macro sees one cycle with reset released before the first command.
- IDLE: a request is accepted when req_valid && req_ready; the state moves to ISSUE. In IDLE, pin_ui is 0x00 and pin_uio_drive is 0x00.
- ISSUE (exactly 1 cycle):
  - pin_ui = {op, addr, func}.
  - WRITE: pin_uio = req_data, pin_uio_drive = 0xFF.
  - COMPUTE: pin_uio = {4'h0, req_data[3:0]}, pin_uio_drive = 0xFF.
  - NOP and READ: pin_uio = 0x00, pin_uio_drive = 0x00.
  - Next state: NOP and WRITE go straight to RESP with rsp_data = 0x00; READ and COMPUTE go to WAIT.
- WAIT: lasts RESP_LAT cycles. pin_ui and pin_uio_drive return to 0x00. pin_uo is sampled into rsp_data at the end of the last WAIT cycle, i.e. the cycle that is RESP_LAT cycles after the ISSUE cycle. The state then moves to RESP.
- RESP: rsp_valid = 1, with rsp_data and rsp_op stable until rsp_valid && rsp_ready. On that handshake rsp_valid drops and the state moves to IDLE. rsp_ready high outside RESP has no effect.
- Latency with the request accepted in cycle 0:
  - Pin command appears in cycle 1.
  - READ/COMPUTE: rsp_valid first high in cycle RESP_LAT+2.
  - NOP/WRITE: rsp_valid first high in cycle 2.
- Exactly one outstanding request. While busy, req_valid is ignored and the request fields may change freely.
- Request fields are captured into registers at acceptance; they are never read after that.
- The WAIT counter is ceil(log2(RESP_LAT+1)) bits wide and reloads on every ISSUE. Back-to-back requests cannot wrap it.
- rst asserted in any state, including WAIT or RESP: next cycle all outputs take their reset values, any pending response is discarded, and the INIT sequence reruns.

Test Plan:
- Reset release: hold rst 3 cycles, then release -> pin_rst_n low for exactly 4 cycles; pin_ena rises with it; req_ready first high one cycle later.
- WRITE: op=01, addr=0x5, data=0xA7 -> one cycle pin_ui=0x54, pin_uio=0xA7, pin_uio_drive=0xFF; then rsp_valid with rsp_data=0x00, rsp_op=01 two cycles after acceptance.
- READ: op=10, addr=0x5; bench model drives pin_uo=0xA7 exactly RESP_LAT cycles after the command cycle and 0x00 otherwise -> rsp_data=0xA7, rsp_valid in cycle 4.
- COMPUTE: op=11, addr=0x3, func=10, data=0x09; pin_uo=0x3C at the sample cycle -> pin_ui=0xCE, pin_uio=0x09, rsp_data=0x3C, rsp_op=11.
- Backpressure: hold rsp_ready low 5 cycles in RESP while toggling req_valid and pin_uo -> rsp_data stays stable, req_ready stays 0, no second command reaches pin_ui.
- Reset mid-WAIT: assert rst during a READ's WAIT -> rsp_valid never rises; pins return to reset values; INIT repeats; the next READ completes correctly.
